// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the async-FIFO read-side stream adapter.
package fifo_rd_pkg;
  localparam int OBUF_DEPTH = 3;
  typedef logic [1:0] lvl_t;

  // Circular pointer advance over the OBUF_DEPTH slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OBUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/stream_obuf.sv
// 3-entry circular output buffer; head is the oldest word, level the occupancy.
module stream_obuf
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             wrst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             rd_en,
  output logic [DSIZE-1:0] head,
  output lvl_t             level
);
  logic [OBUF_DEPTH-1:0][DSIZE-1:0] mem;
  logic [1:0]                       wr_ptr, rd_ptr;

  always_ff @(posedge rclk or negedge wrst_n) begin
    if (!wrst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      // Contents are left in place; only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the async FIFO read port, absorbs its 1-cycle latency, and presents a framed
// valid/ready stream. rinc depends only on registered state, never on m_ready.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic             rclk,
  input  logic             wrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  input  logic             flush,
  output logic [CNT_W-1:0] beat_cnt,
  output lvl_t             level
);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic inflight, pop, capture, hs;

  // Credit: every buffered word plus the one in flight must fit in the buffer.
  assign rinc    = wrst_n & ~rempty & ~flush &
                   (({1'b0, level} + {2'b00, inflight}) < 3'(OBUF_DEPTH));
  assign pop     = rinc & ~rempty;
  assign capture = inflight & ~flush;
  assign m_valid = (level != '0);
  assign hs      = m_valid & m_ready;
  assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

  always_ff @(posedge rclk or negedge wrst_n) begin
    if (!wrst_n) inflight <= 1'b0;
    else         inflight <= pop & ~flush;
  end

  always_ff @(posedge rclk or negedge wrst_n) begin
    if (!wrst_n)    beat_cnt <= '0;
    else if (flush) beat_cnt <= '0;
    else if (hs)    beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
  end

  stream_obuf #(.DSIZE(DSIZE)) u_obuf (
    .rclk    (rclk),
    .wrst_n  (wrst_n),
    .flush   (flush),
    .wr_en   (capture),
    .wr_data (rdata),
    .rd_en   (hs),
    .head    (m_data),
    .level   (level)
  );

  a_no_overflow: assert property (@(posedge rclk) disable iff (!wrst_n)
    !(capture && !hs && level == 2'd3));
endmodule
